ripple_carry_counter: RTL and testbench

RIPPLE_CARRY_COUNTER -- requirements
Module: ripple_carry_counter

---
 rtl/ripple_carry_counter_pkg.sv | 5 +
 rtl/ripple_carry_counter_t_ff.sv | 18 +
 rtl/ripple_carry_counter.sv | 39 +++
 tb/tb_ripple_carry_counter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ripple_carry_counter_pkg.sv
// Shared constants for the ripple counter: default and maximum chain length.
package rcc_pkg;
  localparam int RCC_WIDTH_DEF = 4;
  localparam int RCC_WIDTH_MAX = 16;
endpackage

// File: rtl/ripple_carry_counter_t_ff.sv
// Falling-edge toggle flop with asynchronous active-low clear; one stage of the ripple chain.
module t_ff (
  input  logic clk,
  input  logic rst,
  output logic q
);
  logic q_q;
  logic q_d;

  assign q_d = ~q_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) q_q <= 1'b0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/ripple_carry_counter.sv
// Asynchronous ripple up-counter: stage 0 toggles on clk falling edges, stage i on q[i-1] falling edges.
// Optional terminal-count output tc is enabled by macro RIPPLE_CARRY_COUNTER_TC_EN.
module ripple_carry_counter
  import rcc_pkg::*;
#(
  parameter int WIDTH = RCC_WIDTH_DEF
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             rst
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
  ,
  output logic             tc
`endif
);
  logic [WIDTH-1:0] stage_clk;

  if (WIDTH < 2 || WIDTH > RCC_WIDTH_MAX) begin : g_width_chk
    $error("ripple_carry_counter: WIDTH out of range");
  end

  // Each stage is clocked by the previous stage's output, so a 1->0 carry ripples upward.
  assign stage_clk[0] = clk;
  for (genvar i = 1; i < WIDTH; i++) begin : g_clk
    assign stage_clk[i] = q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    t_ff u_t_ff (
      .clk (stage_clk[i]),
      .rst (rst),
      .q   (q[i])
    );
  end

`ifdef RIPPLE_CARRY_COUNTER_TC_EN
  assign tc = &q;
`endif
endmodule

// File: tb/tb_ripple_carry_counter.sv
// Directed checks of the ripple counter at WIDTH=4 and WIDTH=8 against a hand-built timing table.
`timescale 1ns/1ps
module tb_ripple_carry_counter;
  logic       clk;
  logic       rst;
  logic [3:0] q;
  logic [7:0] q8;
  logic       tc;
  logic       tc8;

  int checks   = 0;
  int failures = 0;

  ripple_carry_counter #(.WIDTH(4)) dut (
    .q   (q),
    .clk (clk),
    .rst (rst)
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
    ,
    .tc  (tc)
`endif
  );

  ripple_carry_counter #(.WIDTH(8)) dut8 (
    .q   (q8),
    .clk (clk),
    .rst (rst)
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
    ,
    .tc  (tc8)
`endif
  );

`ifndef RIPPLE_CARRY_COUNTER_TC_EN
  assign tc  = 1'b0;
  assign tc8 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int t, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  // q must never move on a rising clk edge while reset is inactive.
  logic [3:0] pq;
  logic [7:0] pq8;
  logic       pr;
  always @(posedge clk) begin
    pq  = q;
    pq8 = q8;
    pr  = rst;
    #1;
    if (pr && rst) begin
      chk("rise_hold_q4", int'($time), 16'(q), 16'(pq));
      chk("rise_hold_q8", int'($time), 16'(q8), 16'(pq8));
    end
  end

  typedef struct {
    int         t;
    logic [3:0] q;
    logic [7:0] q8;
    logic       tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int t, input int qv, input int q8v);
    vec_t v;
    v.t  = t;
    v.q  = 4'(qv);
    v.q8 = 8'(q8v);
    v.tc = (qv == 15);
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    #15  rst = 1'b1;
    #180 rst = 1'b0;
    #10  rst = 1'b1;
  end

  initial begin
    // Reset window, including across the 10 ns falling edge.
    vecs.push_back(mk(1, 0, 0));
    vecs.push_back(mk(9, 0, 0));
    vecs.push_back(mk(11, 0, 0));
    vecs.push_back(mk(14, 0, 0));
    for (int n = 1; n <= 15; n++) begin
      vecs.push_back(mk(10 * (n + 1) + 1, n, n));
      if (n == 1)  vecs.push_back(mk(26, 1, 1));
      if (n == 15) vecs.push_back(mk(166, 15, 15));
    end
    // Wrap for the 4-bit counter; the 8-bit one keeps going.
    vecs.push_back(mk(171, 0, 16));
    vecs.push_back(mk(181, 1, 17));
    vecs.push_back(mk(191, 2, 18));
    // Mid-count reset 195..205 with no falling edge at 195.
    vecs.push_back(mk(196, 0, 0));
    vecs.push_back(mk(201, 0, 0));
    vecs.push_back(mk(204, 0, 0));
    vecs.push_back(mk(211, 1, 1));
    vecs.push_back(mk(221, 2, 2));

    foreach (vecs[i]) begin
      if (vecs[i].t > $time) #(vecs[i].t - $time);
      chk("q4", vecs[i].t, 16'(q), 16'(vecs[i].q));
      chk("q8", vecs[i].t, 16'(q8), 16'(vecs[i].q8));
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
      chk("tc", vecs[i].t, 16'(tc), 16'(vecs[i].tc));
      chk("tc8", vecs[i].t, 16'(tc8), 16'(0));
`endif
    end

    // Reset between edges, then run the 8-bit counter through its full range.
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_q4", int'($time), 16'(q), 16'(0));
    chk("async_rst_q8", int'($time), 16'(q8), 16'(0));
    #3;
    rst = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      #1;
      if (k == 16 || k >= 254) begin
        chk("long_q8", int'($time), 16'(q8), 16'(k % 256));
        chk("long_q4", int'($time), 16'(q), 16'(k % 16));
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
        chk("long_tc8", int'($time), 16'(tc8), 16'((k % 256) == 255));
        chk("long_tc", int'($time), 16'(tc), 16'((k % 16) == 15));
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
